psram_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the PSRAM controller.
- Port 0 is the audio record/write path; port 1 is the playback/read path. Either port may issue reads or writes.
- Converts per-port request/done handshakes into the controller's go/mem_idle protocol.
- Returns read data to the owning port; a watchdog catches a controller that never responds.

---
 rtl/psram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_psram_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the PSRAM controller.
// Turns per-port req/ack/done handshakes into the controller's go/idle protocol, guarded by a watchdog.
module psram_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 63
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be_n,
    output logic              p0_ack,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be_n,
    output logic              p1_ack,
    output logic              p1_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_go,
    output logic              mem_command,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [1:0]        mem_byte_en,
    input  logic              mem_idle,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [7:0]        wdog_q, wdog_d;
    logic [7:0]        wdog_inc;
    logic              wdog_hit;
    logic              sel;
    logic              mem_go_q, mem_go_d;
    logic              mem_command_q, mem_command_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_out_q, mem_data_out_d;
    logic [1:0]        mem_byte_en_q, mem_byte_en_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;

    // wdog counts cycles already spent in ISSUE/BUSY; abort once it would reach TIMEOUT
    assign wdog_inc = wdog_q + 8'd1;
    assign wdog_hit = (wdog_inc == 8'(TIMEOUT));
    assign sel      = (p0_req && p1_req) ? ~last_grant_q : p1_req;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        wdog_d         = wdog_q;
        mem_go_d       = mem_go_q;
        mem_command_d  = mem_command_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        mem_byte_en_d  = mem_byte_en_q;
        rd_data_d      = rd_data_q;
        timeout_err_d  = timeout_err_q;
        p0_ack_d       = 1'b0;
        p1_ack_d       = 1'b0;
        p0_done_d      = 1'b0;
        p1_done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    owner_d        = sel;
                    last_grant_d   = sel;
                    mem_command_d  = sel ? ~p1_we : ~p0_we;
                    mem_addr_d     = sel ? p1_addr : p0_addr;
                    mem_data_out_d = sel ? p1_wdata : p0_wdata;
                    mem_byte_en_d  = sel ? p1_be_n : p0_be_n;
                    mem_go_d       = 1'b1;
                    p0_ack_d       = ~sel;
                    p1_ack_d       = sel;
                    wdog_d         = '0;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_idle) begin
                    mem_go_d = 1'b0;
                    wdog_d   = '0;
                    state_d  = S_BUSY;
                end else if (wdog_hit) begin
                    mem_go_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    p0_done_d     = ~owner_q;
                    p1_done_d     = owner_q;
                    state_d       = S_DONE;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            S_BUSY: begin
                if (mem_idle) begin
                    if (mem_command_q) begin
                        rd_data_d = mem_data_in;
                    end
                    p0_done_d = ~owner_q;
                    p1_done_d = owner_q;
                    state_d   = S_DONE;
                end else if (wdog_hit) begin
                    timeout_err_d = 1'b1;
                    p0_done_d     = ~owner_q;
                    p1_done_d     = owner_q;
                    state_d       = S_DONE;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            S_DONE: begin
                mem_command_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            wdog_q         <= '0;
            mem_go_q       <= 1'b0;
            mem_command_q  <= 1'b1;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            mem_byte_en_q  <= 2'b11;
            rd_data_q      <= '0;
            timeout_err_q  <= 1'b0;
            p0_ack_q       <= 1'b0;
            p1_ack_q       <= 1'b0;
            p0_done_q      <= 1'b0;
            p1_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            wdog_q         <= wdog_d;
            mem_go_q       <= mem_go_d;
            mem_command_q  <= mem_command_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            mem_byte_en_q  <= mem_byte_en_d;
            rd_data_q      <= rd_data_d;
            timeout_err_q  <= timeout_err_d;
            p0_ack_q       <= p0_ack_d;
            p1_ack_q       <= p1_ack_d;
            p0_done_q      <= p0_done_d;
            p1_done_q      <= p1_done_d;
        end
    end

    assign p0_ack       = p0_ack_q;
    assign p1_ack       = p1_ack_q;
    assign p0_done      = p0_done_q;
    assign p1_done      = p1_done_q;
    assign rd_data      = rd_data_q;
    assign mem_go       = mem_go_q;
    assign mem_command  = mem_command_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_byte_en  = mem_byte_en_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: PSRAM controller model, vector table, corner sequences and a
// randomized two-port run checked against a memory/ownership reference model.
`timescale 1ns/1ps
module tb_psram_arbiter;
    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 10;

    logic              sysclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic [1:0]        p0_be_n = 2'b11;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic [1:0]        p1_be_n = 2'b11;
    logic              p0_ack, p0_done, p1_ack, p1_done;
    logic [DATA_W-1:0] rd_data;
    logic              mem_go, mem_command;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic [1:0]        mem_byte_en;
    logic              mem_idle;
    logic [DATA_W-1:0] mem_data_in = '0;
    logic              busy, timeout_err;

    int errors = 0;
    int checks = 0;

    psram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .sysclk(sysclk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_be_n(p0_be_n), .p0_ack(p0_ack), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_be_n(p1_be_n), .p1_ack(p1_ack), .p1_done(p1_done),
        .rd_data(rd_data), .mem_go(mem_go), .mem_command(mem_command),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_byte_en(mem_byte_en),
        .mem_idle(mem_idle), .mem_data_in(mem_data_in),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 sysclk = ~sysclk;

    // Controller model: accepts go while idle and out of hold, stays busy for a latency, then holds.
    logic [15:0]       cmem [0:255] = '{default: 16'h0000};
    logic [15:0]       ref_mem [0:255] = '{default: 16'h0000};
    logic              c_idle = 1'b1;
    logic              c_stuck = 1'b0;
    logic              c_rand = 1'b0;
    int                c_hold_len = 3;
    int                c_cnt = 0;
    int                c_hold = 0;
    int                c_accepts = 0;
    logic              c_cmd = 1'b1;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0;
    logic [1:0]        c_be = 2'b11;

    assign mem_idle = c_idle;

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            c_idle      <= 1'b1;
            c_cnt       <= 0;
            c_hold      <= 0;
            mem_data_in <= '0;
        end else if (!c_idle) begin
            if (c_cnt <= 1) begin
                c_idle <= 1'b1;
                c_hold <= c_hold_len;
                if (c_cmd) begin
                    mem_data_in <= cmem[c_addr[7:0]];
                end else begin
                    if (!c_be[0]) cmem[c_addr[7:0]][7:0]  <= c_wdata[7:0];
                    if (!c_be[1]) cmem[c_addr[7:0]][15:8] <= c_wdata[15:8];
                end
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else if (c_hold > 0) begin
            c_hold <= c_hold - 1;
        end else if (mem_go && !c_stuck) begin
            c_idle    <= 1'b0;
            c_cmd     <= mem_command;
            c_addr    <= mem_addr;
            c_wdata   <= mem_data_out;
            c_be      <= mem_byte_en;
            c_cnt     <= c_rand ? int'($urandom_range(1, 8)) : (mem_command ? 5 : 9);
            c_accepts <= c_accepts + 1;
        end
    end

    typedef struct {
        int                port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        be_n;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            input logic [1:0] be);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be_n = be;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be_n = be;
        end
    endtask

    task automatic do_reset();
        set_port(0, 1'b0, 1'b0, '0, '0, 2'b11);
        set_port(1, 1'b0, 1'b0, '0, '0, 2'b11);
        rst_n = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_go"}, mem_go, 0);
        check({tag, "_cmd"}, mem_command, 1);
        check({tag, "_be"}, mem_byte_en, 2'b11);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_data_out, 0);
        check({tag, "_rd"}, rd_data, 0);
        check({tag, "_acks"}, {p0_ack, p1_ack, p0_done, p1_done}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_terr"}, timeout_err, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic got_done, prev_go, prev_idle, fall_seen, my_ack, ot_ack;
        int   other_act, extra;
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata, v.be_n);
        @(negedge sysclk);
        my_ack = (v.port == 0) ? p0_ack : p1_ack;
        ot_ack = (v.port == 0) ? p1_ack : p0_ack;
        check("vec_ack_lat", my_ack, 1);
        check("vec_ack_other", ot_ack, 0);
        check("vec_go", mem_go, 1);
        check("vec_busy", busy, 1);
        check("vec_cmd", mem_command, !v.we);
        check("vec_addr", mem_addr, v.addr);
        check("vec_wdata", mem_data_out, v.wdata);
        check("vec_be", mem_byte_en, v.be_n);
        // requester fields may change once acked
        set_port(v.port, 1'b1, !v.we, ~v.addr, ~v.wdata, ~v.be_n);
        prev_go = mem_go; prev_idle = mem_idle; fall_seen = 1'b0; got_done = 1'b0; other_act = 0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            @(negedge sysclk);
            if (prev_go && !mem_go && !fall_seen) begin
                check("vec_go_fall", prev_idle, 0);
                fall_seen = 1'b1;
            end
            prev_go = mem_go; prev_idle = mem_idle;
            other_act += (v.port == 0) ? int'(p1_ack) + int'(p1_done) : int'(p0_ack) + int'(p0_done);
            if ((v.port == 0 && p0_done) || (v.port == 1 && p1_done)) begin
                got_done = 1'b1;
                if (!v.we) check("vec_rd_data", rd_data, v.exp_rd);
                set_port(v.port, 1'b0, 1'b0, '0, '0, 2'b11);
            end
        end
        check("vec_done_seen", got_done, 1);
        check("vec_go_fell", fall_seen, 1);
        check("vec_other_quiet", other_act, 0);
        extra = 0;
        repeat (4) begin
            @(negedge sysclk);
            extra += int'(p0_ack) + int'(p1_ack) + int'(p0_done) + int'(p1_done);
        end
        check("vec_single_done", extra, 0);
        check("vec_cmd_idle", mem_command, 1);
        check("vec_idle", busy, 0);
    endtask

    task automatic run_tie();
        int order[$];
        int ndone, overlap;
        ndone = 0; overlap = 0;
        set_port(0, 1'b1, 1'b0, 26'h10, 16'h0, 2'b00);
        set_port(1, 1'b1, 1'b0, 26'h20, 16'h0, 2'b00);
        for (int c = 0; c < 300 && ndone < 4; c++) begin
            @(negedge sysclk);
            if (p0_ack && p1_ack) overlap++;
            if (p0_done && p1_done) overlap++;
            if (p0_ack) order.push_back(0);
            if (p1_ack) order.push_back(1);
            ndone += int'(p0_done) + int'(p1_done);
            if (ndone == 4) begin
                set_port(0, 1'b0, 1'b0, '0, '0, 2'b11);
                set_port(1, 1'b0, 1'b0, '0, '0, 2'b11);
            end
        end
        check("tie_dones", ndone, 4);
        check("tie_overlap", overlap, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_order%0d", i), (i < order.size()) ? order[i] : 9, i % 2);
        end
        overlap = 0;
        repeat (5) begin
            @(negedge sysclk);
            overlap += int'(p0_ack) + int'(p1_ack);
        end
        check("tie_dropped_not_granted", overlap, 0);
    endtask

    task automatic run_b2b();
        int acks, dones, acc0, bad_fall;
        logic prev_go, prev_idle;
        c_hold_len = 5;
        acks = 0; dones = 0; bad_fall = 0; acc0 = c_accepts;
        prev_go = 1'b0; prev_idle = 1'b1;
        set_port(1, 1'b1, 1'b0, 26'h10, 16'h0, 2'b11);
        for (int c = 0; c < 120 && dones < 2; c++) begin
            @(negedge sysclk);
            if (prev_go && !mem_go && prev_idle) bad_fall++;
            prev_go = mem_go; prev_idle = mem_idle;
            acks += int'(p1_ack) + int'(p0_ack);
            if (p1_done) begin
                dones++;
                check("b2b_rd", rd_data, 16'h12CD);
                if (dones == 2) set_port(1, 1'b0, 1'b0, '0, '0, 2'b11);
            end
        end
        repeat (6) begin
            @(negedge sysclk);
            acks += int'(p1_ack) + int'(p0_ack);
        end
        check("b2b_acks", acks, 2);
        check("b2b_dones", dones, 2);
        check("b2b_accepts", c_accepts - acc0, 2);
        check("b2b_go_held", bad_fall, 0);
        c_hold_len = 3;
    endtask

    task automatic run_random();
        int st[2];
        int waitc[2];
        int max_wait, m_last, completed;
        logic cr[2], cw[2], tw[2], a[2], d[2], r[2];
        logic [ADDR_W-1:0] ca[2], ta[2];
        logic [DATA_W-1:0] cd[2], td[2];
        logic [1:0] cb[2], tb[2];
        logic [7:0] idx;
        m_last = 1; completed = 0; max_wait = 0;
        for (int p = 0; p < 2; p++) begin
            st[p] = 0; waitc[p] = 0; cr[p] = 1'b0; cw[p] = 1'b0;
            ca[p] = '0; cd[p] = '0; cb[p] = 2'b11;
            tw[p] = 1'b0; ta[p] = '0; td[p] = '0; tb[p] = 2'b11;
        end
        c_rand = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge sysclk);
            a[0] = p0_ack; a[1] = p1_ack; d[0] = p0_done; d[1] = p1_done;
            r[0] = cr[0]; r[1] = cr[1];
            if (a[0] || a[1]) check("rnd_ack_excl", a[0] & a[1], 0);
            if (d[0] || d[1]) check("rnd_done_excl", d[0] & d[1], 0);
            for (int p = 0; p < 2; p++) begin
                if (a[p]) begin
                    check("rnd_ack_req", st[p], 1);
                    if (r[0] && r[1]) check("rnd_round_robin", p, 1 - m_last);
                    m_last = p;
                    tw[p] = cw[p]; ta[p] = ca[p]; td[p] = cd[p]; tb[p] = cb[p];
                    if (waitc[p] > max_wait) max_wait = waitc[p];
                    st[p] = 2;
                    cw[p] = 1'($urandom); ca[p] = ADDR_W'($urandom);
                    cd[p] = DATA_W'($urandom); cb[p] = 2'($urandom);
                    if ($urandom % 2 == 0) cr[p] = 1'b0;
                end else if (d[p]) begin
                    check("rnd_done_owner", st[p], 2);
                    check("rnd_ctl_cmd", c_cmd, !tw[p]);
                    check("rnd_ctl_addr", c_addr, ta[p]);
                    check("rnd_ctl_wdata", c_wdata, td[p]);
                    check("rnd_ctl_be", c_be, tb[p]);
                    idx = ta[p][7:0];
                    if (!tw[p]) begin
                        check("rnd_rd_data", rd_data, ref_mem[idx]);
                    end else begin
                        if (!tb[p][0]) ref_mem[idx][7:0]  = td[p][7:0];
                        if (!tb[p][1]) ref_mem[idx][15:8] = td[p][15:8];
                    end
                    completed++;
                    if (cyc < 2800 && $urandom % 4 == 0) begin
                        st[p] = 1; waitc[p] = 0; cr[p] = 1'b1; cw[p] = 1'($urandom);
                        ca[p] = ADDR_W'(128 + $urandom % 16); cd[p] = DATA_W'($urandom);
                        cb[p] = 2'($urandom);
                    end else begin
                        st[p] = 0; cr[p] = 1'b0;
                    end
                end else if (st[p] == 1) begin
                    waitc[p]++;
                    if ($urandom % 16 == 0) begin
                        st[p] = 0; cr[p] = 1'b0;
                    end
                end else if (st[p] == 0 && cyc < 2800 && $urandom % 4 == 0) begin
                    st[p] = 1; waitc[p] = 0; cr[p] = 1'b1; cw[p] = 1'($urandom);
                    ca[p] = ADDR_W'(128 + $urandom % 16); cd[p] = DATA_W'($urandom);
                    cb[p] = 2'($urandom);
                end
            end
            set_port(0, cr[0], cw[0], ca[0], cd[0], cb[0]);
            set_port(1, cr[1], cw[1], ca[1], cd[1], cb[1]);
        end
        c_rand = 1'b0;
        check("rnd_drained", st[0] + st[1], 0);
        check("rnd_max_wait", max_wait <= 30, 1);
        check("rnd_completed", completed >= 80, 1);
        check("rnd_terr", timeout_err, 0);
    endtask

    task automatic run_timeout();
        logic [DATA_W-1:0] prev_rd;
        int gocnt, idle_low;
        logic got_done;
        vec_t v;
        check("to_terr_before", timeout_err, 0);
        prev_rd = rd_data;
        c_stuck = 1'b1;
        set_port(0, 1'b1, 1'b0, 26'h10, 16'h0, 2'b11);
        @(negedge sysclk);
        check("to_ack", p0_ack, 1);
        gocnt = int'(mem_go); idle_low = 0; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge sysclk);
            gocnt += int'(mem_go);
            idle_low += int'(!mem_idle);
            if (p0_done) begin
                got_done = 1'b1;
                check("to_err_at_done", timeout_err, 1);
                check("to_rd_unchanged", rd_data, prev_rd);
                set_port(0, 1'b0, 1'b0, '0, '0, 2'b11);
            end
        end
        check("to_done", got_done, 1);
        check("to_go_cycles", gocnt, TIMEOUT);
        check("to_idle_never_fell", idle_low, 0);
        c_stuck = 1'b0;
        repeat (3) @(negedge sysclk);
        check("to_err_sticky", timeout_err, 1);
        v.port = 1; v.we = 1'b0; v.addr = 26'h10; v.wdata = '0; v.be_n = 2'b11; v.exp_rd = 16'h12CD;
        run_vec(v);
        check("to_err_sticky2", timeout_err, 1);
    endtask

    task automatic run_reset_mid();
        logic found, got_done;
        found = 1'b0; got_done = 1'b0;
        set_port(1, 1'b1, 1'b1, 26'h40, 16'h9999, 2'b00);
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge sysclk);
            if (busy && !mem_go && !mem_idle) found = 1'b1;
        end
        check("rst_reached_busy", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        check("arst_ctl_idle", mem_idle, 1);
        set_port(1, 1'b0, 1'b0, '0, '0, 2'b11);
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        set_port(0, 1'b1, 1'b0, 26'h10, 16'h0, 2'b11);
        set_port(1, 1'b1, 1'b0, 26'h20, 16'h0, 2'b11);
        @(negedge sysclk);
        check("rst_tie_p0", p0_ack, 1);
        check("rst_tie_p1", p1_ack, 0);
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge sysclk);
            if (p0_done) begin
                got_done = 1'b1;
                check("rst_rd", rd_data, 16'h12CD);
                set_port(0, 1'b0, 1'b0, '0, '0, 2'b11);
                set_port(1, 1'b0, 1'b0, '0, '0, 2'b11);
            end
        end
        check("rst_done", got_done, 1);
        repeat (4) @(negedge sysclk);
        check("rst_final_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{port: 0, we: 1'b1, addr: 26'h10, wdata: 16'h1234, be_n: 2'b00, exp_rd: 16'h0000};
        vecs[1] = '{port: 1, we: 1'b0, addr: 26'h10, wdata: 16'h0000, be_n: 2'b11, exp_rd: 16'h1234};
        vecs[2] = '{port: 1, we: 1'b1, addr: 26'h10, wdata: 16'hABCD, be_n: 2'b10, exp_rd: 16'h0000};
        vecs[3] = '{port: 0, we: 1'b0, addr: 26'h10, wdata: 16'h0000, be_n: 2'b00, exp_rd: 16'h12CD};
        vecs[4] = '{port: 0, we: 1'b1, addr: 26'h20, wdata: 16'h5678, be_n: 2'b01, exp_rd: 16'h0000};
        vecs[5] = '{port: 1, we: 1'b0, addr: 26'h20, wdata: 16'hFFFF, be_n: 2'b11, exp_rd: 16'h5600};
        vecs[6] = '{port: 0, we: 1'b0, addr: 26'h30, wdata: 16'h0000, be_n: 2'b11, exp_rd: 16'h0000};

        do_reset();
        check_reset_vals("reset");
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        do_reset();
        run_tie();
        run_b2b();

        do_reset();
        run_random();
        run_timeout();
        run_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
